// File: rtl/cpu_mem_pkg.sv
// Shared types for the CPU-to-memory access path: controller FSM states,
// requester identity and default bus widths.
package cpu_mem_pkg;

    localparam int DEF_AW = 4;
    localparam int DEF_DW = 16;

    typedef enum logic [1:0] {
        IDLE,
        CMD,
        WAIT,
        RESP
    } state_e;

    typedef enum logic {
        REQ_IF,
        REQ_LS
    } req_id_e;

endpackage

// File: rtl/mem_arb.sv
// Fixed-priority fetch / load-store arbiter. A starvation counter lets the
// fetch port win once load/store traffic has beaten it MAX_STARVE times in a row.
module mem_arb
    import cpu_mem_pkg::*;
#(
    parameter int MAX_STARVE = 3
) (
    input  logic    CLK,
    input  logic    reset,
    input  logic    arb_en,
    input  logic    if_req,
    input  logic    ls_req,
    output logic    if_gnt,
    output logic    ls_gnt,
    output req_id_e gnt_id
);

    localparam int SW = $clog2(MAX_STARVE + 1);
    localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_STARVE);

    logic [SW-1:0] starve_q, starve_d;
    logic          if_wins;

    // NOTE: every always_comb output gets a default on entry so no path leaves
    // a signal unassigned and infers a latch.
    always_comb begin
        if_wins  = if_req && (!ls_req || (starve_q == STARVE_MAX));
        if_gnt   = arb_en && if_wins;
        ls_gnt   = arb_en && ls_req && !if_wins;
        gnt_id   = if_wins ? REQ_IF : REQ_LS;
        starve_d = starve_q;
        if (arb_en) begin
            if (!if_req || if_gnt) begin
                starve_d = '0;
            end else if (ls_gnt && (starve_q != STARVE_MAX)) begin
                starve_d = starve_q + SW'(1);
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge value of its inputs regardless of process ordering.
    always_ff @(posedge CLK) begin
        if (reset) begin
            starve_q <= '0;
        end else begin
            starve_q <= starve_d;
        end
    end

endmodule

// File: rtl/mem_access_ctrl.sv
// Memory-side initiator: arbitrates fetch and load/store requests and issues one
// single-cycle memory command per access, returning data with an rvalid pulse.
module mem_access_ctrl
    import cpu_mem_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int RD_LAT     = 1,
    parameter int MAX_STARVE = 3
) (
    input  logic          CLK,
    input  logic          reset,
    input  logic          if_req,
    input  logic [AW-1:0] if_addr,
    output logic          if_gnt,
    output logic          if_rvalid,
    output logic [DW-1:0] if_rdata,
    input  logic          ls_req,
    input  logic          ls_we,
    input  logic [AW-1:0] ls_addr,
    input  logic [DW-1:0] ls_wdata,
    output logic          ls_gnt,
    output logic          ls_rvalid,
    output logic [DW-1:0] ls_rdata,
    output logic          MemRead,
    output logic          MemWrite,
    output logic [AW-1:0] ADDR,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    localparam int LW = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;

    state_e        state_q, state_d;
    req_id_e       id_q, id_d;
    logic          we_q, we_d;
    logic [AW-1:0] addr_q, addr_d;
    logic [DW-1:0] wdata_q, wdata_d;
    logic [LW-1:0] lat_q, lat_d;
    logic [DW-1:0] if_rdata_q, if_rdata_d;
    logic [DW-1:0] ls_rdata_q, ls_rdata_d;

    logic    arb_en;
    req_id_e gnt_id;

    // Grants are only offered while idle, and never in a reset cycle.
    assign arb_en = (state_q == IDLE) && !reset;

    mem_arb #(
        .MAX_STARVE (MAX_STARVE)
    ) u_arb (
        .CLK    (CLK),
        .reset  (reset),
        .arb_en (arb_en),
        .if_req (if_req),
        .ls_req (ls_req),
        .if_gnt (if_gnt),
        .ls_gnt (ls_gnt),
        .gnt_id (gnt_id)
    );

    always_comb begin
        state_d    = state_q;
        id_d       = id_q;
        we_d       = we_q;
        addr_d     = addr_q;
        wdata_d    = wdata_q;
        lat_d      = lat_q;
        if_rdata_d = if_rdata_q;
        ls_rdata_d = ls_rdata_q;
        unique case (state_q)
            IDLE: begin
                if (if_gnt || ls_gnt) begin
                    id_d = gnt_id;
                    if (ls_gnt) begin
                        we_d    = ls_we;
                        addr_d  = ls_addr;
                        wdata_d = ls_wdata;
                    end else begin
                        we_d   = 1'b0;
                        addr_d = if_addr;
                    end
                    state_d = CMD;
                end
            end
            CMD: begin
                if (we_q) begin
                    ls_rdata_d = '0;
                    state_d    = RESP;
                end else begin
                    lat_d   = LW'(RD_LAT - 1);
                    state_d = WAIT;
                end
            end
            WAIT: begin
                if (lat_q == '0) begin
                    if (id_q == REQ_IF) begin
                        if_rdata_d = mem_rdata;
                    end else begin
                        ls_rdata_d = mem_rdata;
                    end
                    state_d = RESP;
                end else begin
                    lat_d = lat_q - LW'(1);
                end
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            state_q    <= IDLE;
            id_q       <= REQ_IF;
            we_q       <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            lat_q      <= '0;
            if_rdata_q <= '0;
            ls_rdata_q <= '0;
        end else begin
            state_q    <= state_d;
            id_q       <= id_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            wdata_q    <= wdata_d;
            lat_q      <= lat_d;
            if_rdata_q <= if_rdata_d;
            ls_rdata_q <= ls_rdata_d;
        end
    end

    assign MemRead   = (state_q == CMD) && !we_q;
    assign MemWrite  = (state_q == CMD) && we_q;
    assign ADDR      = addr_q;
    assign mem_wdata = wdata_q;
    assign if_rvalid = (state_q == RESP) && (id_q == REQ_IF);
    assign ls_rvalid = (state_q == RESP) && (id_q == REQ_LS);
    assign if_rdata  = if_rdata_q;
    assign ls_rdata  = ls_rdata_q;

endmodule

// File: doc/mem_access_ctrl.md
# mem_access_ctrl

Memory-side initiator sitting between the CPU core and the 16-word memory. Accepts instruction-fetch and load/store requests from the core, arbitrates them, and drives the memory's MemRead/MemWrite/ADDR/data strobes for exactly one command cycle per access. Returns read data to the winning requester with a registered valid pulse. A starvation counter guarantees fetch progress under continuous load/store traffic.

## Interface

Parameters:
- AW, 4, address width (memory depth 2^AW)
- DW, 16, data width
- RD_LAT, 1, memory read latency in cycles from MemRead cycle to valid mem_rdata (≥1)
- MAX_STARVE, 3, consecutive fetch losses before fetch is forced to win

Ports (one clock; reset is synchronous and active-high):
- CLK  in  1  clock, all state on rising edge
- reset  in  1  synchronous active-high reset
- if_req  in  1  fetch request, held with if_addr until if_gnt
- if_addr  in  AW  fetch address
- if_gnt  out  1  fetch request accepted this cycle (combinational)
- if_rvalid  out  1  one-cycle pulse: if_rdata valid
- if_rdata  out  DW  fetch read data
- ls_req  in  1  load/store request, held with ls_we/ls_addr/ls_wdata until ls_gnt
- ls_we  in  1  1 = store, 0 = load
- ls_addr  in  AW  load/store address
- ls_wdata  in  DW  store data
- ls_gnt  out  1  load/store accepted this cycle (combinational)
- ls_rvalid  out  1  one-cycle pulse: load data valid, or store acknowledged
- ls_rdata  out  DW  load data (0 for store ack)
- MemRead  out  1  memory read strobe
- MemWrite  out  1  memory write strobe
- ADDR  out  AW  memory address
- mem_wdata  out  DW  data to memory Data_in
- mem_rdata  in  DW  data from memory Data_out

## Operation

- FSM states: IDLE, CMD, WAIT, RESP.
- IDLE: grant at most one requester; latch id, we, addr, wdata at grant; → CMD. No request → stay.
- Arbitration: ls wins over if, except when if_req=1 and starve_cnt==MAX_STARVE → if wins.
- starve_cnt: +1 when if_req=1 and ls granted; cleared on if grant, when if_req=0 in IDLE, and on reset; saturates at MAX_STARVE.
- CMD: exactly one of MemRead/MemWrite high for one cycle; ADDR/mem_wdata from latches. Read → WAIT; write → RESP.
- WAIT: RD_LAT cycles; capture mem_rdata into data register in last WAIT cycle; → RESP.
- RESP: pulse rvalid of the granted requester; rdata = captured data (store: 0); → IDLE.
- gnt only asserted in IDLE; requests in other states wait.
- MemRead and MemWrite never simultaneously high; both 0 outside CMD.
- ADDR/mem_wdata hold last latched values between accesses.

## Timing

- Reset values: all gnt/rvalid/MemRead/MemWrite 0; ADDR 0; mem_wdata 0; if_rdata/ls_rdata 0; state IDLE; starve_cnt 0.
- Read: grant cycle T; MemRead at T+1; capture at T+1+RD_LAT; rvalid at T+2+RD_LAT; next grant earliest T+3+RD_LAT.
- Write: grant T; MemWrite at T+1; ls_rvalid ack at T+2; next grant earliest T+3.
- Reset asserted in any state: next cycle IDLE, in-flight response dropped (no rvalid), strobes 0. Reset overrides simultaneous requests.
- rdata outputs hold value after rvalid until next response.

## Structure

- Package cpu_mem_pkg: state enum (IDLE/CMD/WAIT/RESP), requester id type (REQ_IF/REQ_LS), default AW/DW constants.
- Sub-module mem_arb: priority selection plus starve_cnt; outputs grant id and gnt pulses. FSM, latches and latency counter stay in mem_access_ctrl.

## Test plan

- Memory preloaded mem[0]=16'h13F7, RD_LAT=1; if_req addr 0 in IDLE → if_gnt same cycle, MemRead one cycle later with ADDR=0, if_rvalid=1 with if_rdata=16'h13F7 exactly 3 cycles after grant.
- ls store addr 5 data 16'hBEEF then load addr 5 → MemWrite single-cycle pulse with ADDR=5, ack ls_rvalid with ls_rdata=0 at grant+2; load returns 16'hBEEF.
- if_req and ls_req held high continuously, MAX_STARVE=3 → grant order LS,LS,LS,IF,LS,LS,LS,IF; no cycle with both gnt high.
- reset pulsed in WAIT of a load → next cycle all outputs at reset values, no ls_rvalid ever for that load; new request granted immediately after.
- RD_LAT=2 → read rvalid 4 cycles after grant; data captured from mem_rdata 3 cycles after grant.
- Requests raised during CMD/WAIT/RESP → no gnt until IDLE; assertion MemRead&MemWrite never 1 throughout all tests.
